// File: rtl/sum_deserializer.sv
// Packs the 1-bit s1/s2/c result streams LSB-first into W-bit words and queues them in a DEPTH-entry FWFT FIFO.
// Words appear one cycle after the completing edge; a completed word that meets a full FIFO with no pop is dropped and drop_err sticks.
// SUM_DESER_PARITY_EN adds out_par, an odd-ones flag per stream stored alongside each word.
module sum_deserializer #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic                 s1,
    input  logic                 s2,
    input  logic                 c,
    input  logic                 clr,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_s1,
    output logic [W-1:0]         out_s2,
    output logic [W-1:0]         out_c,
    output logic                 drop_err,
`ifdef SUM_DESER_PARITY_EN
    output logic [2:0]           out_par,
`endif
    output logic [$clog2(W)-1:0] bit_cnt
);

    localparam int CW = $clog2(W);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [AW:0]   PONE = 1;

    typedef enum logic {IDLE, COLLECT} state_t;
    state_t state;

    logic [W-1:0] sh_s1, sh_s2, sh_c;
    logic [W-1:0] word_s1, word_s2, word_c;
    logic         push_req, push, pop, empty, full;
    logic [AW:0]  wptr, rptr;
    logic [AW-1:0] widx, ridx;

    // The incoming bit merged into the partial word; a fresh word always starts from zero.
    always_comb begin
        word_s1 = (state == COLLECT) ? sh_s1 : '0;
        word_s2 = (state == COLLECT) ? sh_s2 : '0;
        word_c  = (state == COLLECT) ? sh_c  : '0;
        word_s1[bit_cnt] = s1;
        word_s2[bit_cnt] = s2;
        word_c[bit_cnt]  = c;
    end

    assign push_req = in_valid && !clr && (bit_cnt == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sh_s1   <= '0;
            sh_s2   <= '0;
            sh_c    <= '0;
        end else if (clr) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sh_s1   <= '0;
            sh_s2   <= '0;
            sh_c    <= '0;
        end else if (in_valid) begin
            if (bit_cnt == LAST) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sh_s1   <= '0;
                sh_s2   <= '0;
                sh_c    <= '0;
            end else begin
                state   <= COLLECT;
                bit_cnt <= bit_cnt + CW'(1);
                sh_s1   <= word_s1;
                sh_s2   <= word_s2;
                sh_c    <= word_c;
            end
        end
    end

    assign widx  = wptr[AW-1:0];
    assign ridx  = rptr[AW-1:0];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (widx == ridx);
    assign pop   = !empty && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push  = push_req && (!full || pop);

    logic [W-1:0] mem_s1 [DEPTH];
    logic [W-1:0] mem_s2 [DEPTH];
    logic [W-1:0] mem_c  [DEPTH];
    logic [W-1:0] hold_s1, hold_s2, hold_c;
`ifdef SUM_DESER_PARITY_EN
    logic [2:0] mem_par [DEPTH];
    logic [2:0] hold_par;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_s1[widx] <= word_s1;
            mem_s2[widx] <= word_s2;
            mem_c[widx]  <= word_c;
`ifdef SUM_DESER_PARITY_EN
            mem_par[widx] <= {^word_c, ^word_s2, ^word_s1};
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            drop_err <= 1'b0;
            hold_s1  <= '0;
            hold_s2  <= '0;
            hold_c   <= '0;
`ifdef SUM_DESER_PARITY_EN
            hold_par <= '0;
`endif
        end else begin
            if (push)
                wptr <= wptr + PONE;
            if (push_req && !push)
                drop_err <= 1'b1;
            if (pop) begin
                rptr    <= rptr + PONE;
                hold_s1 <= mem_s1[ridx];
                hold_s2 <= mem_s2[ridx];
                hold_c  <= mem_c[ridx];
`ifdef SUM_DESER_PARITY_EN
                hold_par <= mem_par[ridx];
`endif
            end
        end
    end

    // With the FIFO empty the outputs show the last word handed over.
    assign out_valid = !empty;
    assign out_s1    = empty ? hold_s1 : mem_s1[ridx];
    assign out_s2    = empty ? hold_s2 : mem_s2[ridx];
    assign out_c     = empty ? hold_c  : mem_c[ridx];
`ifdef SUM_DESER_PARITY_EN
    assign out_par   = empty ? hold_par : mem_par[ridx];
`endif

endmodule

// File: tb/tb_sum_deserializer.sv
// Directed bench for sum_deserializer (W=8, DEPTH=2): a queue-based model checked every cycle plus literal expectations.
module tb_sum_deserializer;

    localparam int W = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rstn, in_valid, s1, s2, c, clr, out_ready;
    logic out_valid, drop_err;
    logic [W-1:0] out_s1, out_s2, out_c;
    logic [2:0] bit_cnt;
`ifdef SUM_DESER_PARITY_EN
    logic [2:0] out_par;
`endif

    sum_deserializer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .s1(s1), .s2(s2), .c(c),
        .clr(clr), .out_ready(out_ready), .out_valid(out_valid),
        .out_s1(out_s1), .out_s2(out_s2), .out_c(out_c), .drop_err(drop_err),
`ifdef SUM_DESER_PARITY_EN
        .out_par(out_par),
`endif
        .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bits gathered as plain integers, completed words as {c,s2,s1} in a queue.
    int           m_cnt;
    logic [W-1:0] m_p1, m_p2, m_pc;
    logic [3*W-1:0] m_q[$];
    logic [3*W-1:0] m_last;
    logic         m_drop;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt = 0; m_p1 = '0; m_p2 = '0; m_pc = '0;
            m_q.delete(); m_last = '0; m_drop = 1'b0;
        end else begin
            bit was_full, do_pop, completes;
            logic [3*W-1:0] w;
            was_full  = (m_q.size() == DEPTH);
            do_pop    = (m_q.size() > 0) && out_ready;
            completes = 1'b0;
            if (clr) begin
                m_cnt = 0; m_p1 = '0; m_p2 = '0; m_pc = '0;
            end else if (in_valid) begin
                m_p1[m_cnt] = s1; m_p2[m_cnt] = s2; m_pc[m_cnt] = c;
                m_cnt++;
                if (m_cnt == W) begin
                    completes = 1'b1;
                    w = {m_pc, m_p2, m_p1};
                    m_cnt = 0; m_p1 = '0; m_p2 = '0; m_pc = '0;
                end
            end
            if (do_pop) m_last = m_q.pop_front();
            if (completes) begin
                if (!was_full || do_pop) m_q.push_back(w);
                else m_drop = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [3*W-1:0] head;
        head = (m_q.size() > 0) ? m_q[0] : m_last;
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("out_s1", 32'(out_s1), 32'(head[W-1:0]));
        chk("out_s2", 32'(out_s2), 32'(head[2*W-1:W]));
        chk("out_c", 32'(out_c), 32'(head[3*W-1:2*W]));
        chk("drop_err", 32'(drop_err), 32'(m_drop));
        chk("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
`ifdef SUM_DESER_PARITY_EN
        chk("out_par", 32'(out_par), 32'({^head[3*W-1:2*W], ^head[2*W-1:W], ^head[W-1:0]}));
`endif
    end

    task automatic step(input logic v, input logic b1, input logic b2, input logic bc, input logic cl);
        @(posedge clk); #1;
        in_valid = v; s1 = b1; s2 = b2; c = bc; clr = cl;
    endtask

    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] cc, input bit gap);
        for (int i = 0; i < W; i++) begin
            step(1'b1, a[i], b[i], cc[i], 1'b0);
            if (gap) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int xfers;
        rstn = 1'b0; in_valid = 0; s1 = 0; s2 = 0; c = 0; clr = 0; out_ready = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_s1", 32'(out_s1), 0);
        chk("rst_bitcnt", 32'(bit_cnt), 0);
        rstn = 1'b1;
        idle(1);

        // Basic packing: s1 bits 1,0,1,1,0,0,1,0 LSB-first.
        send_word(8'h4D, 8'hFF, 8'h00, 1'b0);
        @(negedge clk);
        chk("basic_valid", 32'(out_valid), 1);
        chk("basic_s1", 32'(out_s1), 32'h4D);
        chk("basic_s2", 32'(out_s2), 32'hFF);
        chk("basic_c", 32'(out_c), 32'h00);
`ifdef SUM_DESER_PARITY_EN
        chk("basic_par", 32'(out_par), 0);
`endif
        @(posedge clk); #1; out_ready = 1;
        step(1'b0, 0, 0, 0, 0); out_ready = 0;

        // Gapped input, then 5 cycles of backpressure.
        send_word(8'h4D, 8'hFF, 8'h00, 1'b1);
        idle(5);
        @(negedge clk);
        chk("bp_hold_s1", 32'(out_s1), 32'h4D);
        @(posedge clk); #1; out_ready = 1;
        step(1'b0, 0, 0, 0, 0); out_ready = 0;
        @(negedge clk);
        chk("bp_popped", 32'(out_valid), 0);
        chk("bp_last_s1", 32'(out_s1), 32'h4D);

        // Overflow: three words into a two-entry FIFO.
        send_word(8'h11, 8'hEE, 8'h0F, 1'b0);
        send_word(8'h22, 8'hDD, 8'hF0, 1'b0);
        send_word(8'h33, 8'hCC, 8'h55, 1'b0);
        @(negedge clk);
        chk("ovf_drop", 32'(drop_err), 1);
        chk("ovf_valid", 32'(out_valid), 1);
        chk("ovf_head", 32'(out_s1), 32'h11);
        @(posedge clk); #1; out_ready = 1;
        xfers = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) xfers++;
            @(posedge clk); #1;
        end
        out_ready = 0;
        chk("ovf_xfers", 32'(xfers), 2);
        chk("ovf_last_s1", 32'(out_s1), 32'h22);

        // Reset pulse mid-word at bit_cnt=5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_bitcnt", 32'(bit_cnt), 5);
        #2 rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_bitcnt", 32'(bit_cnt), 0);
        chk("mid_rst_drop", 32'(drop_err), 0);
        chk("mid_rst_s1", 32'(out_s1), 0);
        @(posedge clk); #1; rstn = 1'b1;

        // Full FIFO with push and pop on the same edge.
        send_word(8'hA1, 8'h01, 8'h80, 1'b0);
        send_word(8'hA2, 8'h02, 8'h40, 1'b0);
        for (int i = 0; i < W - 1; i++) step(1'b1, i[0] ^ 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); out_ready = 1;
        step(1'b0, 0, 0, 0, 0); out_ready = 0;
        @(negedge clk);
        chk("sim_drop", 32'(drop_err), 0);
        chk("sim_head", 32'(out_s1), 32'hA2);
        @(posedge clk); #1; out_ready = 1;
        idle(2); out_ready = 0;
        @(negedge clk);
        chk("sim_last", 32'(out_s1), 32'hD5);

        // clr after 3 bits (together with in_valid), then a clean word.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 0, 0, 0, 0);
        @(negedge clk);
        chk("clr_bitcnt", 32'(bit_cnt), 0);
        chk("clr_noword", 32'(out_valid), 0);
        send_word(8'hFF, 8'h00, 8'h81, 1'b0);
        @(negedge clk);
        chk("clr_clean", 32'(out_s1), 32'hFF);
        @(posedge clk); #1; out_ready = 1;
        step(1'b0, 0, 0, 0, 0); out_ready = 0;

        // clr on the completing edge: no word.
        for (int i = 0; i < W - 1; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 0, 0, 0, 0);
        idle(1);
        @(negedge clk);
        chk("clr_last_noword", 32'(out_valid), 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_deserializer.md
Name: sum_deserializer

Overview:
- Downstream stage of `example`. Consumes its per-cycle 1-bit results `s1`, `s2` and `c`.
- Packs successive bits, LSB-first, into W-bit words for each of the three result streams.
- Delivers words through a small first-word-fall-through (FWFT) output FIFO with a valid/ready handshake.
- Lets word-level checkers and scoreboards work on packed results instead of single bits.

Parameters:
- W, 8, word width in bits; must be ≥2.
- DEPTH, 2, output FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  `s1`/`s2`/`c` hold a valid bit this cycle.
- s1  in  1  sum bit 1 from `example`.
- s2  in  1  sum bit 2 from `example`.
- c  in  1  carry bit from `example`.
- clr  in  1  synchronous discard of the partial word.
- out_ready  in  1  consumer accepts the head word.
- out_valid  out  1  FIFO non-empty.
- out_s1  out  W  packed `s1` word at FIFO head.
- out_s2  out  W  packed `s2` word at FIFO head.
- out_c  out  W  packed `c` word at FIFO head.
- drop_err  out  1  sticky: a completed word was lost because the FIFO was full.
- bit_cnt  out  $clog2(W)  bits collected in the current word (debug).

Behaviour:
- Reset (rstn=0, async, any time, including mid-word):
  - counter=0, shift registers=0, FIFO empty.
  - out_valid=0, out_s1/out_s2/out_c=0, drop_err=0, bit_cnt=0.
- States:
  - IDLE (bit_cnt=0, no partial word) and COLLECT (1 ≤ bit_cnt ≤ W-1).
  - IDLE→COLLECT on in_valid.
  - COLLECT→IDLE when the W-th bit is taken, or on clr.
- Collection:
  - Each cycle with in_valid=1, the bit at index bit_cnt of each stream is written. Bit k of a word is the k-th valid sample, LSB-first.
  - in_valid=0 holds all state; gaps between bits are allowed.
- Word completion:
  - Occurs on the edge where in_valid=1 and bit_cnt=W-1.
  - The full word (new bit included) is pushed into the FIFO on that same edge and bit_cnt wraps to 0.
- Latency:
  - Last bit sampled at edge N, FIFO previously empty → out_valid=1 and data valid after edge N (visible in cycle N+1).
- Handshake:
  - Transfer happens when out_valid & out_ready at posedge; the head is popped.
  - out_s1/out_s2/out_c are stable while out_valid=1 && out_ready=0.
  - When out_valid=0, the data outputs hold the last value (0 after reset).
  - out_ready with empty FIFO: no effect.
- Full FIFO:
  - A push while full with no pop in the same cycle: the word is dropped, drop_err is set (cleared only by reset), and the FIFO is unchanged.
  - Push and pop in the same cycle while full: both succeed; the count is unchanged.
  - Push and pop in the same cycle while empty: the word enters the FIFO, out_valid=1 the next cycle (no bypass).
- clr:
  - Zeroes bit_cnt and the partial shift registers on the next edge; the FIFO is untouched.
  - clr together with in_valid: clr wins and the bit is discarded.
  - clr on the completing edge: the word is not pushed.
- Pointers: $clog2(DEPTH)+1-bit read/write pointers with wrap; full/empty derived from the MSB compare.

Optional Feature:
- SUM_DESER_PARITY_EN
  - Defined: adds output out_par [2:0], stored alongside each word.
    - out_par[0] = ^word_s1, out_par[1] = ^word_s2, out_par[2] = ^word_c (even parity, 1 if odd number of ones).
    - Same timing, hold and reset (0) rules as out_s1.
  - Undefined: port and storage are absent; all other behaviour is identical.

Test Plan:
- Reset checks:
  - Assert rstn=0 at t=0, release after 2 clk → out_valid=0, all data outputs 0, drop_err=0, bit_cnt=0.
  - Repeat with rstn pulsed low mid-word at bit_cnt=5 → same response, and the next word starts at bit 0.
- Basic packing: W=8; in_valid=1 for 8 consecutive cycles with s1=1,0,1,1,0,0,1,0, s2=1, c=0 → one cycle after the 8th edge: out_valid=1, out_s1=8'h4D, out_s2=8'hFF, out_c=8'h00.
  - With SUM_DESER_PARITY_EN: out_par=3'b000.
- Gapped input and backpressure:
  - Same bits with in_valid toggling 1/0 each cycle → identical word.
  - Hold out_ready=0 for 5 cycles → outputs stable; the word pops on the first out_ready=1 edge.
- Overflow: DEPTH=2, out_ready=0, stream 3 full words → first two retained in order; drop_err=1 after the third completes; out_valid stays 1.
  - Then out_ready=1 → exactly 2 transfers.
- Simultaneous push/pop when full: FIFO full, out_ready=1 on the completing edge of a new word → no drop, drop_err stays 0, word order preserved.
- clr: after 3 bits assert clr (with in_valid=1) → bit_cnt=0, no word emitted.
  - The next 8 valid bits form a clean word, e.g. s1 all 1 → out_s1=8'hFF.
